// File: rtl/spi_buffer_ctrl_if.sv
// spi_buffer_ctrl_if: receiver, processor and bank-buffer signals of the SPI ping-pong controller.
// master drives the receiver/processor inputs; slave is the controller itself.
interface spi_buffer_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                  spi_ready;
    logic [DATA_WIDTH-1:0] spi_data;
    logic                  swap;
    logic                  pu_rd;
    logic [1:0]            buf_wr_en;
    logic [ADDR_WIDTH-1:0] buf_wr_addr;
    logic [DATA_WIDTH-1:0] buf_wr_data;
    logic                  buf_rd_bank;
    logic [ADDR_WIDTH-1:0] buf_rd_addr;
    logic [ADDR_WIDTH-1:0] rd_len;
    logic                  frame_valid;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output spi_ready, spi_data, swap, pu_rd,
        input  buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_bank, buf_rd_addr,
               rd_len, frame_valid, overflow, underflow
    );

    modport slave (
        input  spi_ready, spi_data, swap, pu_rd,
        output buf_wr_en, buf_wr_addr, buf_wr_data, buf_rd_bank, buf_rd_addr,
               rd_len, frame_valid, overflow, underflow
    );
endinterface

// File: rtl/spi_buffer_ctrl.sv
// spi_buffer_ctrl: ping-pong fill/read bank controller between an SPI byte receiver and a processor.
// Define SPI_BUF_WRAP_EN to make a full fill bank wrap and overwrite instead of dropping bytes.
module spi_buffer_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_SIZE   = 6,
    parameter int ADDR_WIDTH = 3
) (
    input logic              clk,
    input logic              rst,
    spi_buffer_ctrl_if.slave bus
);
    localparam logic [0:0]            ST_FILL  = 1'b0;
    localparam logic [0:0]            ST_FULL  = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(BUF_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] PTR_SIZE = ADDR_WIDTH'(BUF_SIZE);

    logic [0:0]            state;
    logic                  spi_q;
    logic                  fill_bank;
    logic                  byte_ev;
    logic                  accept;
    logic                  drop;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] wr_ptr_next;
    logic [ADDR_WIDTH-1:0] swap_len;
`ifdef SPI_BUF_WRAP_EN
    logic                  wrapped;
`endif

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path leaves it unassigned and infers a latch.
        byte_ev     = bus.spi_ready & ~spi_q;
        drop        = byte_ev && (state == ST_FULL);
        accept      = 1'b0;
        wr_ptr_next = wr_ptr;
        swap_len    = wr_ptr;
`ifdef SPI_BUF_WRAP_EN
        accept = byte_ev;
        if (accept)
            wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
        // Once the bank has wrapped every entry holds live data.
        swap_len = wrapped ? PTR_SIZE : (accept ? wr_ptr + PTR_ONE : wr_ptr);
`else
        accept = byte_ev && (state == ST_FILL);
        if (accept)
            wr_ptr_next = wr_ptr + PTR_ONE;
        swap_len = accept ? wr_ptr + PTR_ONE : wr_ptr;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spi_q           <= 1'b1;
            state           <= ST_FILL;
            fill_bank       <= 1'b0;
            wr_ptr          <= '0;
            bus.buf_wr_en   <= 2'b00;
            bus.buf_wr_addr <= '0;
            bus.buf_wr_data <= {DATA_WIDTH{1'b0}};
            bus.buf_rd_bank <= 1'b1;
            bus.buf_rd_addr <= '0;
            bus.rd_len      <= '0;
            bus.overflow    <= 1'b0;
            bus.underflow   <= 1'b0;
`ifdef SPI_BUF_WRAP_EN
            wrapped         <= 1'b0;
`endif
        end else begin
            spi_q         <= bus.spi_ready;
            bus.buf_wr_en <= 2'b00;
            // A byte coinciding with swap still lands in the bank being handed over.
            if (accept) begin
                bus.buf_wr_en   <= fill_bank ? 2'b10 : 2'b01;
                bus.buf_wr_addr <= wr_ptr;
                bus.buf_wr_data <= bus.spi_data;
            end
            if (drop)
                bus.overflow <= 1'b1;
`ifdef SPI_BUF_WRAP_EN
            if (accept && wrapped)
                bus.overflow <= 1'b1;
`endif
            if (bus.swap) begin
                fill_bank       <= ~fill_bank;
                bus.buf_rd_bank <= fill_bank;
                bus.rd_len      <= swap_len;
                bus.buf_rd_addr <= '0;
                wr_ptr          <= '0;
                state           <= ST_FILL;
`ifdef SPI_BUF_WRAP_EN
                wrapped         <= 1'b0;
`endif
            end else begin
                wr_ptr <= wr_ptr_next;
`ifdef SPI_BUF_WRAP_EN
                if (accept && (wr_ptr == PTR_LAST))
                    wrapped <= 1'b1;
`else
                if (accept && (wr_ptr_next == PTR_SIZE))
                    state <= ST_FULL;
`endif
                if (bus.pu_rd) begin
                    if (bus.buf_rd_addr < bus.rd_len)
                        bus.buf_rd_addr <= bus.buf_rd_addr + PTR_ONE;
                    else
                        bus.underflow <= 1'b1;
                end
            end
        end
    end

    assign bus.frame_valid = bus.buf_rd_addr < bus.rd_len;
endmodule

// File: doc/spi_buffer_ctrl.md
# spi_buffer_ctrl

Ping-pong controller for a pair of SPI byte buffers, `BUF_SIZE` entries each. It sits between the SPI receiver and the processor unit. It turns the receiver's level-held `spi_ready` strobe into exactly one write per byte into the current fill bank. It exposes the other bank to the processor for sequential reads and exchanges the banks on a processor `swap` pulse at the end of each computation cycle.

## Interface
- `DATA_WIDTH`, 8, byte/word width
- `BUF_SIZE`, 6, entries per bank (≥1)
- `ADDR_WIDTH`, 3, address width; must satisfy 2^ADDR_WIDTH > BUF_SIZE
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `spi_ready` in 1, byte-valid level from the SPI receiver; may stay high for several cycles per byte
- `spi_data` in DATA_WIDTH, byte accompanying `spi_ready`
- `swap` in 1, single-cycle pulse: exchange fill and read banks
- `pu_rd` in 1, single-cycle read strobe: advance read pointer
- `buf_wr_en` out 2, one-hot write strobe, bit i = bank i
- `buf_wr_addr` out ADDR_WIDTH, write address
- `buf_wr_data` out DATA_WIDTH, registered write data
- `buf_rd_bank` out 1, bank currently presented for reading
- `buf_rd_addr` out ADDR_WIDTH, read address in `buf_rd_bank`
- `rd_len` out ADDR_WIDTH, valid entries in the read bank
- `frame_valid` out 1, high while `buf_rd_addr < rd_len`
- `overflow` out 1, sticky: a byte arrived while the fill bank was full
- `underflow` out 1, sticky: `pu_rd` arrived with no entries left

## Operation
- **Edge detect.** `spi_q` holds `spi_ready` from the previous cycle. A byte event is `spi_ready & ~spi_q`. `spi_q` resets to 1, so a level that is already high when reset releases does not count as a byte.
- **Write side state machine (states FILL and FULL).**
  - FILL, byte event with `wr_ptr < BUF_SIZE`: next cycle, `buf_wr_en[fill_bank]`=1, `buf_wr_addr`=`wr_ptr`, `buf_wr_data`=`spi_data` as sampled at the event; then `wr_ptr`++.
  - `wr_ptr` reaching BUF_SIZE moves the machine to FULL.
  - FULL, byte event: the byte is dropped, `overflow` is set, no write occurs.
- **Swap.**
  - `fill_bank` toggles and `buf_rd_bank` becomes the old fill bank.
  - `rd_len` ← `wr_ptr`, plus 1 if a byte event is being committed in the same cycle into the old bank. A byte event coinciding with `swap` goes to the old bank if it is in FILL, otherwise it is dropped.
  - `wr_ptr` ← 0, state ← FILL, `buf_rd_addr` ← 0.
  - Unread entries in the old read bank are discarded silently.
- **Read side.** `pu_rd` with `buf_rd_addr < rd_len` increments `buf_rd_addr`. `pu_rd` with `buf_rd_addr == rd_len` leaves the address unchanged and sets `underflow`. When `pu_rd` and `swap` occur in the same cycle, `swap` wins and the read is ignored, with no underflow.
- **Sticky flags.** `overflow` and `underflow` clear only on `rst`.
- **Arithmetic.** `wr_ptr` is ADDR_WIDTH bits, compared to BUF_SIZE unsigned; it never exceeds BUF_SIZE.

## Timing
- Reset values: `buf_wr_en`=0, `buf_wr_addr`=0, `buf_wr_data`=0, fill bank 0, `buf_rd_bank`=1, `buf_rd_addr`=0, `rd_len`=0, `frame_valid`=0, `overflow`=0, `underflow`=0, state FILL.
- Reset is asynchronous: asserting `rst` mid-write forces `buf_wr_en` to 0 immediately and the pending byte is lost.
- Write latency: byte event in cycle t gives `buf_wr_en` high in cycle t+1, for exactly one cycle, regardless of how long `spi_ready` stays high.
- Byte rate: at most one byte event per two cycles, because `spi_ready` must be low at least one cycle between bytes.
- `swap` in cycle t: `buf_rd_bank`, `rd_len`, `buf_rd_addr` and `frame_valid` are updated in cycle t+1. A write committed in t+1 still targets the old bank.
- `pu_rd` in cycle t: `buf_rd_addr` is updated in t+1. The buffer read data for the new address is the external buffer's concern.

## Configuration
- `SPI_BUF_WRAP_EN` defined: FULL is never entered. A byte event at `wr_ptr == BUF_SIZE-1` writes that entry and wraps `wr_ptr` to 0. Later bytes overwrite from address 0 and set `overflow` on each overwrite. `rd_len` on swap is BUF_SIZE once a wrap has occurred.
- Not defined: drop-on-full behaviour as described in Operation.

## Test plan
- **Reset, then single bytes.** `rst` pulse, then bytes 2, 3, 4 each with `spi_ready` held 2 cycles and low 4 cycles → exactly three `buf_wr_en`=01 pulses at addresses 0, 1, 2 with data 2, 3, 4.
- **Swap and read.** After the above, `swap` → `buf_rd_bank`=0, `rd_len`=3, `frame_valid`=1. Four `pu_rd` → `buf_rd_addr` goes 1, 2, 3, 3; `frame_valid` drops after the third read; `underflow`=1 after the fourth.
- **Overflow.** Seven bytes 1..7 without swap → six writes at addresses 0..5, the seventh is dropped, `overflow`=1. With `SPI_BUF_WRAP_EN` the seventh byte is written to address 0 with data 7 instead.
- **Simultaneous swap and byte.** Two bytes written, then a third byte event in the same cycle as `swap` → write goes to bank 0 at address 2, `rd_len`=3, the next byte goes to bank 1 at address 0.
- **Reset edge cases.** `spi_ready` held high across reset release → no write. `rst` asserted in the cycle after a byte event → `buf_wr_en` falls immediately and all outputs return to their reset values.
